// File: rtl/dm_pkg.sv
// Shared types and byte-lane placement for the data-memory store responder.
// Big-endian lanes: byte offset 0 lives in bits [31:24], and be[3] enables that byte.
package dm_pkg;

  localparam logic [1:0] DM_SZ_WORD = 2'd0;
  localparam logic [1:0] DM_SZ_BYTE = 2'd1;
  localparam logic [1:0] DM_SZ_HALF = 2'd2;
  localparam logic [1:0] DM_SZ_TRI  = 2'd3;

  // Wide enough for any index a 32-bit byte address can carry; the top zero-extends.
  localparam int DM_IDX_W = 30;

  typedef struct packed {
    logic [DM_IDX_W-1:0] idx;
    logic [31:0]         data;
    logic [3:0]          be;
  } dm_sb_entry_t;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } dm_lane_t;

  // Left-align the n source bytes, then shift right by the offset; bytes pushed
  // past offset 3 fall off the end instead of wrapping into the next word.
  function automatic dm_lane_t dm_lane_place(input logic [1:0]  addr_lo,
                                             input logic [1:0]  size,
                                             input logic [31:0] data);
    dm_lane_t    r;
    logic [2:0]  n;
    logic [1:0]  lo;
    logic [2:0]  pad;
    logic [31:0] src;
    logic [3:0]  mask;
    n    = (size == DM_SZ_WORD) ? 3'd4 : {1'b0, size};
    lo   = (size == DM_SZ_WORD) ? 2'd0 : addr_lo;
    pad  = 3'd4 - n;
    src  = data << {pad, 3'b000};
    mask = 4'hF << pad;
    r.be   = mask >> lo;
    r.data = src >> {lo, 3'b000};
    return r;
  endfunction

endpackage

// File: rtl/dm_store_buffer.sv
// In-order circular store buffer with a parallel word-index match across valid entries.
module dm_store_buffer
  import dm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  dm_sb_entry_t               entry_i,
  input  logic                       pop_i,
  input  logic [DM_IDX_W-1:0]        match_idx_i,
  output dm_sb_entry_t               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       match_o
);

  localparam int PW = $clog2(DEPTH);

  dm_sb_entry_t   ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]    cnt_q, cnt_d;
  logic           do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = ent_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (do_push) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload needs no reset: an entry is only observed while its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (do_push) ent_q[wr_ptr_q] <= entry_i;
  end

  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i] && ent_q[i].idx == match_idx_i) match_o = 1'b1;
  end

endmodule

// File: rtl/dm_store_responder.sv
// Data-memory responder: combinational word reads, sized stores through a store
// buffer that drains one entry per cycle, and hazard/full stall decode.
module dm_store_responder
  import dm_pkg::*;
#(
  parameter int ADDR_IDX_W = 10,
  parameter int BUF_DEPTH  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] data_address_fMEM,
  input  logic [31:0] data_write_fMEM,
  input  logic [1:0]  data_write_size_fMEM,
  input  logic        MemRead_fMEM,
  input  logic        MemWrite_fMEM,
  output logic [31:0] data_read_2MEM,
  output logic        stall_2MEM
);

  localparam int WORDS = 2 ** ADDR_IDX_W;

  logic [31:0] mem_q [WORDS];

  logic [ADDR_IDX_W-1:0]     req_idx;
  dm_lane_t                  lane;
  dm_sb_entry_t              sb_in, sb_head;
  logic                      sb_full, sb_empty, sb_match, sb_push;
  logic [$clog2(BUF_DEPTH):0] sb_cnt;
  logic                      rd_only;

  assign req_idx = data_address_fMEM[ADDR_IDX_W+1:2];
  assign lane    = dm_lane_place(data_address_fMEM[1:0], data_write_size_fMEM, data_write_fMEM);
  assign sb_in   = '{idx: DM_IDX_W'(req_idx), data: lane.data, be: lane.be};
  assign rd_only = MemRead_fMEM & ~MemWrite_fMEM;

  // A full buffer stalls even when the head drains on the same edge: no bypass.
  assign stall_2MEM = (MemWrite_fMEM & sb_full) | (rd_only & sb_match);
  assign sb_push    = MemWrite_fMEM & ~stall_2MEM;

  dm_store_buffer #(.DEPTH(BUF_DEPTH)) u_sb (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .push_i      (sb_push),
    .entry_i     (sb_in),
    .pop_i       (~sb_empty),
    .match_idx_i (DM_IDX_W'(req_idx)),
    .head_o      (sb_head),
    .full_o      (sb_full),
    .empty_o     (sb_empty),
    .count_o     (sb_cnt),
    .match_o     (sb_match)
  );

  always_ff @(posedge CLK) begin
    if (!sb_empty) begin
      for (int b = 0; b < 4; b++)
        if (sb_head.be[b]) mem_q[sb_head.idx[ADDR_IDX_W-1:0]][8*b +: 8] <= sb_head.data[8*b +: 8];
    end
  end

  assign data_read_2MEM = (rd_only & ~stall_2MEM) ? mem_q[req_idx] : 32'h0;

  // Address bits above the index alias; the buffer's upper index bits are always zero.
  logic unused_ok;
  assign unused_ok = ^{data_address_fMEM[31:ADDR_IDX_W+2], sb_head.idx[DM_IDX_W-1:ADDR_IDX_W], sb_cnt};

endmodule
